vocab_matcher: RTL and testbench
================================

Name: vocab_matcher

Overview:
- Sequential word lookup engine: scans a vocabulary memory of null-terminated words and reports whether an input word is present, plus its index and start address.
- Sits between the tokeniser front end and the tensor_core datapath; drives an external sram read port.
- Parametrised in character width, address depth and maximum word length.
- Explicit FSM with a start/done handshake.

Parameters:
- DATA_WIDTH, 8: bits per character.
- ADDR_WIDTH, 4: vocab memory address width; depth = 2**ADDR_WIDTH.
- MAX_WORD_LEN, 3: maximum characters in the input word.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin lookup; sampled only in IDLE.
- word  input  MAX_WORD_LEN*DATA_WIDTH  input word; char 0 in LSBs; null-padded; latched on accepted start.
- vocab_rd  output  1  read strobe to vocab sram.
- vocab_addr  output  ADDR_WIDTH  read address.
- vocab_dout  input  DATA_WIDTH  sram data, valid one cycle after vocab_rd.
- busy  output  1  high in READ/CMP.
- done  output  1  one-cycle pulse when the lookup finishes.
- found  output  1  match result; held until next accepted start.
- match_idx  output  ADDR_WIDTH  ordinal of the matching vocab word (0-based); held.
- match_addr  output  ADDR_WIDTH  address of the first char of the matching word; held.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal word start, char pointer k and mismatch flag all 0.
- FSM states: IDLE, READ, CMP, DONE.
- IDLE: start=1 latches word; addr=0, k=0, mismatch=0, idx=0, wstart=0; clears found/match_idx/match_addr; moves to READ.
- READ: vocab_rd=1 at vocab_addr; moves to CMP.
- CMP, c=vocab_dout, non-null c:
  - k<MAX_WORD_LEN, word[k]==c and !mismatch: k++.
  - Otherwise: mismatch=1; k does not increment past MAX_WORD_LEN.
- CMP, null c with k==0 and addr==wstart (empty word = end of vocab): found=0, go to DONE.
- CMP, other null c:
  - Match if !mismatch and (k==MAX_WORD_LEN or word[k]==0): found=1, match_idx=idx, match_addr=wstart, go to DONE.
  - Otherwise: idx++, wstart=addr+1, k=0, mismatch=0.
- CMP, otherwise: if addr==2**ADDR_WIDTH-1, go to DONE with found=0 (no wrap); else addr++ and go to READ.
- DONE: done=1 for one cycle; go to IDLE.
- Latency: 2 cycles per vocab char. done asserts 2*(last_addr+1)+1 cycles after the cycle in which start is sampled.
- start while busy/DONE: ignored; latched word unchanged.
- Empty input word (char 0 null): never matches. A null at k==0 is treated as end of vocab, not as a match.
- rst mid-lookup: immediate return to IDLE; all outputs cleared; no done pulse.
- Comparison is exact DATA_WIDTH equality; no X-compare operators.

Optional Feature:
- Macro: VOCAB_MATCHER_CASE_FOLD_EN (requires DATA_WIDTH>=8).
- Defined: both word[k] and c map 8'h41-8'h5A to +8'h20 before comparison, giving ASCII case-insensitive matching. Null detection is unaffected.
- Undefined: exact compare only; no fold logic synthesised.

Test Plan:
- Vocab "cat\0dog\0do\0\0" (addr 0-11), word "do" -> done at cycle 23, found=1, match_idx=2, match_addr=8. The "dog" prefix must not match.
- Same vocab, word "cat" (full MAX_WORD_LEN, no terminator) -> done at cycle 9, found=1, match_idx=0, match_addr=0.
- Same vocab, word "ca" -> done at cycle 25 (double null at addr 11), found=0.
- Vocab with all 16 locations non-null, any word -> done at cycle 33 after CMP of addr 15, found=0, vocab_addr never wraps to 0.
- Reset behaviour:
  - Pulse start during busy -> ignored; result matches a single lookup.
  - Assert rst at cycle 6 -> busy=0, done never pulses, found=0.
  - A following start completes normally.
- With VOCAB_MATCHER_CASE_FOLD_EN: word "DoG" -> found=1, match_idx=1, match_addr=4. Without the macro -> found=0.

Source files
------------

// File: rtl/vocab_matcher.sv
// Sequential vocabulary lookup: walks a null-terminated word list in an external SRAM.
// Optional ASCII case-insensitive compare via VOCAB_MATCHER_CASE_FOLD_EN.
module vocab_matcher #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int MAX_WORD_LEN = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
    output logic                               vocab_rd,
    output logic [ADDR_WIDTH-1:0]              vocab_addr,
    input  logic [DATA_WIDTH-1:0]              vocab_dout,
    output logic                               busy,
    output logic                               done,
    output logic                               found,
    output logic [ADDR_WIDTH-1:0]              match_idx,
    output logic [ADDR_WIDTH-1:0]              match_addr
);

    localparam int KW  = $clog2(MAX_WORD_LEN + 1);
    localparam int NCH = 2 ** KW;
    localparam logic [KW-1:0]         K_MAX     = KW'(MAX_WORD_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_DONE} state_t;

    state_t                            r_state, r_state_next;
    logic [MAX_WORD_LEN*DATA_WIDTH-1:0] r_word, r_word_next;
    logic [ADDR_WIDTH-1:0]             r_addr, r_addr_next;
    logic [ADDR_WIDTH-1:0]             r_wstart, r_wstart_next;
    logic [ADDR_WIDTH-1:0]             r_idx, r_idx_next;
    logic [KW-1:0]                     r_k, r_k_next;
    logic                              r_mismatch, r_mismatch_next;
    logic                              r_found, r_found_next;
    logic [ADDR_WIDTH-1:0]             r_match_idx, r_match_idx_next;
    logic [ADDR_WIDTH-1:0]             r_match_addr, r_match_addr_next;

    // Character table padded with nulls so k == MAX_WORD_LEN reads as a terminator.
    logic [DATA_WIDTH-1:0] w_chars [NCH];
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chars
            if (gi < MAX_WORD_LEN) begin : g_real
                assign w_chars[gi] = r_word[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign w_chars[gi] = '0;
            end
        end
    endgenerate

    logic [DATA_WIDTH-1:0] w_wchar;
    logic                  w_c_null;
    logic                  w_char_eq;

    assign w_wchar  = w_chars[r_k];
    assign w_c_null = (vocab_dout == '0);

`ifdef VOCAB_MATCHER_CASE_FOLD_EN
    function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] c);
        if (c >= DATA_WIDTH'(8'h41) && c <= DATA_WIDTH'(8'h5A))
            return c + DATA_WIDTH'(8'h20);
        return c;
    endfunction
    assign w_char_eq = (fold(w_wchar) == fold(vocab_dout));
`else
    assign w_char_eq = (w_wchar == vocab_dout);
`endif

    always_comb begin
        r_state_next      = r_state;
        r_word_next       = r_word;
        r_addr_next       = r_addr;
        r_wstart_next     = r_wstart;
        r_idx_next        = r_idx;
        r_k_next          = r_k;
        r_mismatch_next   = r_mismatch;
        r_found_next      = r_found;
        r_match_idx_next  = r_match_idx;
        r_match_addr_next = r_match_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_word_next       = word;
                    r_addr_next       = '0;
                    r_wstart_next     = '0;
                    r_idx_next        = '0;
                    r_k_next          = '0;
                    r_mismatch_next   = 1'b0;
                    r_found_next      = 1'b0;
                    r_match_idx_next  = '0;
                    r_match_addr_next = '0;
                    r_state_next      = S_READ;
                end
            end
            S_READ: r_state_next = S_CMP;
            S_CMP: begin
                if (w_c_null && r_k == '0 && r_addr == r_wstart) begin
                    // An empty vocab entry marks the end of the list.
                    r_state_next = S_DONE;
                end else if (w_c_null && !r_mismatch && (r_k == K_MAX || w_wchar == '0)) begin
                    r_found_next      = 1'b1;
                    r_match_idx_next  = r_idx;
                    r_match_addr_next = r_wstart;
                    r_state_next      = S_DONE;
                end else begin
                    if (w_c_null) begin
                        r_idx_next      = r_idx + 1'b1;
                        r_wstart_next   = r_addr + 1'b1;
                        r_k_next        = '0;
                        r_mismatch_next = 1'b0;
                    end else if (r_k < K_MAX && w_char_eq && !r_mismatch) begin
                        r_k_next = r_k + 1'b1;
                    end else begin
                        r_mismatch_next = 1'b1;
                    end
                    if (r_addr == ADDR_LAST) begin
                        r_state_next = S_DONE;
                    end else begin
                        r_addr_next  = r_addr + 1'b1;
                        r_state_next = S_READ;
                    end
                end
            end
            S_DONE:  r_state_next = S_IDLE;
            default: r_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_addr       <= '0;
            r_wstart     <= '0;
            r_idx        <= '0;
            r_k          <= '0;
            r_mismatch   <= 1'b0;
            r_found      <= 1'b0;
            r_match_idx  <= '0;
            r_match_addr <= '0;
        end else begin
            r_state      <= r_state_next;
            r_word       <= r_word_next;
            r_addr       <= r_addr_next;
            r_wstart     <= r_wstart_next;
            r_idx        <= r_idx_next;
            r_k          <= r_k_next;
            r_mismatch   <= r_mismatch_next;
            r_found      <= r_found_next;
            r_match_idx  <= r_match_idx_next;
            r_match_addr <= r_match_addr_next;
        end
    end

    assign vocab_rd   = (r_state == S_READ);
    assign vocab_addr = r_addr;
    assign busy       = (r_state == S_READ) || (r_state == S_CMP);
    assign done       = (r_state == S_DONE);
    assign found      = r_found;
    assign match_idx  = r_match_idx;
    assign match_addr = r_match_addr;

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed bench for vocab_matcher: SRAM model, expected-result queue popped on done.
module tb_vocab_matcher;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int ML = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ML*DW-1:0] word;
    logic             vocab_rd;
    logic [AW-1:0]    vocab_addr;
    logic [DW-1:0]    vocab_dout;
    logic             busy, done, found;
    logic [AW-1:0]    match_idx, match_addr;

    logic [DW-1:0] mem [16];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string tag;
        bit    found;
        int    idx;
        int    addr;
        int    lat;
    } exp_t;
    exp_t sb_q[$];

    vocab_matcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORD_LEN(ML)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word       (word),
        .vocab_rd   (vocab_rd),
        .vocab_addr (vocab_addr),
        .vocab_dout (vocab_dout),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .match_idx  (match_idx),
        .match_addr (match_addr)
    );

    always #5 clk = ~clk;

    // SRAM model: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (vocab_rd) vocab_dout <= mem[vocab_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ML*DW-1:0] pack(input string s);
        logic [ML*DW-1:0] w = '0;
        for (int i = 0; i < s.len() && i < ML; i++) w[i*DW +: DW] = s[i];
        return w;
    endfunction

    task automatic load_std();
        string s = "catxdogxdoxx";
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < s.len(); i++) mem[i] = (s[i] == "x") ? 8'h00 : s[i];
    endtask

    // Runs one lookup; optionally pulses start with another word at negedge 'glitch'.
    task automatic lookup(input string w, input bit efound, input int eidx, input int eaddr,
                          input int elat, input int glitch, input string alt);
        exp_t e;
        exp_t got;
        bit   seen;
        bit   seen_last;
        bit   wrapped;
        int   n;
        e.tag = w; e.found = efound; e.idx = eidx; e.addr = eaddr; e.lat = elat;
        sb_q.push_back(e);
        seen = 1'b0; seen_last = 1'b0; wrapped = 1'b0;
        word  = pack(w);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({w, ":busy_after_start"}, 32'(busy), 32'd1);
                check({w, ":found_cleared"}, 32'(found), 32'd0);
            end
            if (glitch != 0 && n == glitch) begin
                word = pack(alt); start = 1'b1;
            end else if (glitch != 0 && n == glitch + 1) begin
                start = 1'b0; word = pack(w);
            end
            if (seen_last && vocab_addr == '0) wrapped = 1'b1;
            if (vocab_addr == 4'hF) seen_last = 1'b1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        got = sb_q.pop_front();
        if (!seen) begin
            mismatched++;
            $display("FAIL %s:timeout observed no done expected done within 100 cycles", got.tag);
        end else begin
            check({got.tag, ":latency"}, 32'(n), 32'(got.lat));
            check({got.tag, ":found"}, 32'(found), 32'(got.found));
            check({got.tag, ":match_idx"}, 32'(match_idx), 32'(got.idx));
            check({got.tag, ":match_addr"}, 32'(match_addr), 32'(got.addr));
            check({got.tag, ":busy_at_done"}, 32'(busy), 32'd0);
            if (glitch == 0 && got.lat == 33) check({got.tag, ":no_wrap"}, 32'(wrapped), 32'd0);
            @(negedge clk);
            check({got.tag, ":done_one_cycle"}, 32'(done), 32'd0);
            check({got.tag, ":found_held"}, 32'(found), 32'(got.found));
        end
        $display("lookup '%s': found=%0d idx=%0d addr=%0d cycles=%0d", w, found, match_idx, match_addr, n);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; word = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:found", 32'(found), 32'd0);
        check("reset:match_idx", 32'(match_idx), 32'd0);
        check("reset:match_addr", 32'(match_addr), 32'd0);
        check("reset:vocab_rd", 32'(vocab_rd), 32'd0);
        check("reset:vocab_addr", 32'(vocab_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load_std();
        lookup("do", 1'b1, 2, 8, 23, 0, "");
        lookup("cat", 1'b1, 0, 0, 9, 0, "");
        lookup("ca", 1'b0, 0, 0, 25, 0, "");
        lookup("", 1'b0, 0, 0, 25, 0, "");
        lookup("do", 1'b1, 2, 8, 23, 4, "cat");
`ifdef VOCAB_MATCHER_CASE_FOLD_EN
        lookup("DoG", 1'b1, 1, 4, 17, 0, "");
`else
        lookup("DoG", 1'b0, 0, 0, 25, 0, "");
`endif

        // Reset in the middle of a lookup.
        word = pack("do"); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset:busy", 32'(busy), 32'd0);
        check("midreset:found", 32'(found), 32'd0);
        check("midreset:vocab_rd", 32'(vocab_rd), 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midreset:no_done", 32'(dones), 32'd0);
        $display("midreset: busy=%0d found=%0d done_pulses=%0d", busy, found, dones);
        lookup("cat", 1'b1, 0, 0, 9, 0, "");

        // Vocab with no terminators: must stop at the last address.
        for (int i = 0; i < 16; i++) mem[i] = 8'h61 + 8'(i);
        lookup("cat", 1'b0, 0, 0, 33, 0, "");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
